tdc_hit_buffer: RTL and testbench
=================================

# tdc_hit_buffer

Parametrised ping-pong hit buffer between the TDC measurement front end and the AXI-stream style output port. Collects up to DEPTH (tof, intensity) hits per measurement frame into one of two banks, commits the bank at frame end, and drains it as a burst with valid/ready/last while the other bank captures the next frame. Replaces the fixed three-entry result registers and hard-wired drain FSM; adds configurable depth and widths, overlap of capture and drain, drop accounting and optional strongest-N retention.

## Interface
- TOF_W, 10, width of a TOF word (coarse count concatenated with fine phase).
- INT_W, 5, width of the intensity (active-SPAD count).
- DEPTH, 3, hit slots per bank, 1..15.
- CNT_W, $clog2(DEPTH+1), width of hit counts.
- clk  in  1  single clock (250 MHz logic clock); all logic on its rising edge.
- rst  in  1  asynchronous reset, active-high.
- frame_start  in  1  one-cycle pulse; opens a capture frame.
- frame_end  in  1  one-cycle pulse; closes the current frame (range expiry).
- hit_valid  in  1  one-cycle pulse per synchronised trigger.
- hit_tof  in  TOF_W  TOF for this hit.
- hit_int  in  INT_W  intensity for this hit.
- o_data  out  TOF_W  TOF of current beat.
- o_int  out  INT_W  intensity of current beat.
- o_num  out  CNT_W  hit count of the frame being drained, constant over the burst.
- o_valid  out  1  beat valid.
- o_ready  in  1  sink ready.
- o_last  out  1  final beat of the burst.
- o_irq  out  1  one-cycle pulse when a bank commits.
- drop_cnt  out  8  saturating count of frames lost for lack of a free bank.

## Operation
- Bank state per bank: FREE, CAPT, FULL, DRAIN. Reset: both FREE, capture FSM CAP_IDLE, drain FSM DR_IDLE; all outputs 0.
- frame_start in CAP_IDLE: claim lowest-index FREE bank → CAPT, count 0, go CAP_ACTIVE. No FREE bank: go CAP_ACTIVE in discard mode (hits counted, not stored).
- frame_start in CAP_ACTIVE: current frame restarted; its bank count cleared, no commit, no drop.
- hit_valid in CAP_ACTIVE with count < DEPTH: store at slot[count], count+1. hit_valid outside CAP_ACTIVE ignored.
- hit_valid with count == DEPTH: discarded (see Configuration for alternative).
- frame_end in CAP_ACTIVE: count > 0 → bank FULL, o_irq pulse, commit order recorded; count == 0 → bank FREE, no irq. Discard mode with count > 0 → drop_cnt+1 (saturates at 255), no irq. Return to CAP_IDLE.
- Same-cycle hit_valid and frame_end: hit included before commit. Same-cycle frame_end and frame_start: current frame closed, new frame opened same cycle on the other bank if FREE.
- Drain FSM DR_IDLE → DR_SEND when a FULL bank exists (oldest commit first); bank → DRAIN. Beats emitted in slot order 0..count-1; o_last on beat count-1. After last accepted, bank FREE, FSM DR_IDLE.
- Handshake: beat transfers when o_valid & o_ready; o_data/o_int/o_num/o_last held stable while o_valid & !o_ready; o_valid never deasserts before transfer. Beats back-to-back at 1 per cycle within a burst.

## Timing
- frame_end at cycle N: bank FULL and o_irq high at N+1; o_valid high at N+1 if drain idle.
- Last beat accepted at cycle M: o_valid low at M+1; next FULL bank's first beat valid at M+2 (one-cycle gap fixed).
- rst mid-operation: immediate return to reset state; partial bursts abandoned, drop_cnt cleared.

## Configuration
- TDC_MAXINT_EN defined: strongest-N retention. Hit at count == DEPTH replaces the slot with minimum intensity (lowest index on ties) iff hit_int > that minimum (strict); count stays DEPTH. Slot order then is slot index, not arrival.
- Undefined: first-N retention as described in Operation; no comparator logic synthesised.

## Structure
- tdc_pkg: bank state and FSM state encodings, default TOF_W/INT_W, drop counter width.
- Sub-module tdc_min_sel: combinational argmin over DEPTH intensities returning index and value; instantiated only under TDC_MAXINT_EN.

## Test plan
- Single frame, hits (0x05A,3),(0x10F,7): frame_end → o_irq next cycle; beats 0x05A/3 then 0x10F/7, o_num=2, o_last on second, o_ready held high.
- Five hits, DEPTH=3, macro off: only first three drained, o_num=3; macro on with ints 4,2,6,1,5: drained ints 4,5,6 in slot order.
- o_ready low for 4 cycles at first beat: o_valid and data stable throughout, transfer on ready rise.
- Three back-to-back frames with o_ready low: frames 1,2 held, frame 3 dropped, drop_cnt=1; frames 1 then 2 drained in order with one-cycle gap.
- Empty frame (start, end, no hits): no o_irq, no o_valid, bank FREE.
- rst asserted mid-burst: outputs 0 same cycle, next frame drains normally from slot 0.

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared encodings and defaults for the TDC ping-pong hit buffer.
package tdc_pkg;

    localparam int TOF_W_DEF = 10;
    localparam int INT_W_DEF = 5;
    localparam int DROP_W    = 8;

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_CAPT  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_e;

    typedef enum logic {
        CAP_IDLE   = 1'b0,
        CAP_ACTIVE = 1'b1
    } cap_state_e;

    typedef enum logic {
        DR_IDLE = 1'b0,
        DR_SEND = 1'b1
    } dr_state_e;

endpackage

// File: rtl/tdc_min_sel.sv
// Combinational argmin over DEPTH packed intensities; the lowest index wins on ties.
module tdc_min_sel #(
    parameter int DEPTH = 3,
    parameter int INT_W = 5,
    parameter int CNT_W = 2
) (
    input  logic [DEPTH*INT_W-1:0] ints_i,
    output logic [CNT_W-1:0]       min_idx_o,
    output logic [INT_W-1:0]       min_val_o
);

    always_comb begin
        min_idx_o = '0;
        min_val_o = ints_i[INT_W-1:0];
        for (int i = 1; i < DEPTH; i++) begin
            if (ints_i[i*INT_W +: INT_W] < min_val_o) begin
                min_val_o = ints_i[i*INT_W +: INT_W];
                min_idx_o = CNT_W'(i);
            end
        end
    end

endmodule

// File: rtl/tdc_hit_buffer.sv
// Two-bank ping-pong hit buffer: one bank captures a frame while the other drains as a burst.
// Define TDC_MAXINT_EN for strongest-N retention instead of first-N.
module tdc_hit_buffer
    import tdc_pkg::*;
#(
    parameter int TOF_W = TOF_W_DEF,
    parameter int INT_W = INT_W_DEF,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              hit_valid,
    input  logic [TOF_W-1:0]  hit_tof,
    input  logic [INT_W-1:0]  hit_int,
    output logic [TOF_W-1:0]  o_data,
    output logic [INT_W-1:0]  o_int,
    output logic [CNT_W-1:0]  o_num,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              o_irq,
    output logic [DROP_W-1:0] drop_cnt
);

    // Slot arrays are sized to the full count range so a CNT_W index never over-reaches.
    localparam int               SLOTS   = 1 << CNT_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    bank_state_e       bank_q [2];
    bank_state_e       bank_d [2];
    logic [CNT_W-1:0]  bank_cnt_q [2];
    logic [CNT_W-1:0]  bank_cnt_d [2];
    cap_state_e        cap_state_q, cap_state_d;
    logic              cap_bank_q, cap_bank_d;
    logic              cap_disc_q, cap_disc_d;
    logic [CNT_W-1:0]  cap_cnt_q, cap_cnt_d;
    logic              first_q, first_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              irq_q, irq_d;
    dr_state_e         dr_state_q, dr_state_d;
    logic              dr_bank_q, dr_bank_d;
    logic [CNT_W-1:0]  dr_idx_q, dr_idx_d;

    logic              hit_take, wr_en, free0, free1, dr_sel;
    logic [CNT_W-1:0]  wr_slot, cnt_eff, last_idx;

    logic [TOF_W-1:0]  tof_mem [2][SLOTS];
    logic [INT_W-1:0]  int_mem [2][SLOTS];

`ifdef TDC_MAXINT_EN
    logic [DEPTH*INT_W-1:0] min_in;
    logic [CNT_W-1:0]       min_idx;
    logic [INT_W-1:0]       min_val;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_min_in
        assign min_in[gi*INT_W +: INT_W] = int_mem[cap_bank_q][gi];
    end

    tdc_min_sel #(
        .DEPTH (DEPTH),
        .INT_W (INT_W),
        .CNT_W (CNT_W)
    ) u_min_sel (
        .ints_i    (min_in),
        .min_idx_o (min_idx),
        .min_val_o (min_val)
    );
`endif

    assign last_idx = bank_cnt_q[dr_bank_q] - 1'b1;
    assign free0    = (bank_q[0] == BANK_FREE);
    assign free1    = (bank_q[1] == BANK_FREE);

    always_comb begin
        cap_state_d   = cap_state_q;
        cap_bank_d    = cap_bank_q;
        cap_disc_d    = cap_disc_q;
        cap_cnt_d     = cap_cnt_q;
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        bank_cnt_d[0] = bank_cnt_q[0];
        bank_cnt_d[1] = bank_cnt_q[1];
        first_d       = first_q;
        drop_d        = drop_q;
        irq_d         = 1'b0;
        dr_state_d    = dr_state_q;
        dr_bank_d     = dr_bank_q;
        dr_idx_d      = dr_idx_q;
        dr_sel        = 1'b0;
        wr_en         = 1'b0;
        wr_slot       = cap_cnt_q;
        cnt_eff       = cap_cnt_q;

        // A restart without frame_end discards a coincident hit; with frame_end it joins the closing frame.
        hit_take = (cap_state_q == CAP_ACTIVE) && hit_valid && !(frame_start && !frame_end);
        if (hit_take) begin
            if (cap_cnt_q < DEPTH_C) begin
                cnt_eff = cap_cnt_q + 1'b1;
                wr_en   = !cap_disc_q;
            end
`ifdef TDC_MAXINT_EN
            else if (!cap_disc_q && (hit_int > min_val)) begin
                wr_en   = 1'b1;
                wr_slot = min_idx;
            end
`endif
        end

        if (cap_state_q == CAP_ACTIVE) begin
            if (frame_end) begin
                cap_state_d = CAP_IDLE;
                cap_cnt_d   = '0;
                if (cap_disc_q) begin
                    if ((cnt_eff != '0) && (drop_q != '1)) begin
                        drop_d = drop_q + 1'b1;
                    end
                end else if (cnt_eff != '0) begin
                    bank_d[cap_bank_q]     = BANK_FULL;
                    bank_cnt_d[cap_bank_q] = cnt_eff;
                    irq_d                  = 1'b1;
                    first_d = (bank_q[!cap_bank_q] == BANK_FULL) ? !cap_bank_q : cap_bank_q;
                end else begin
                    bank_d[cap_bank_q] = BANK_FREE;
                end
            end else if (frame_start) begin
                cap_cnt_d = '0;
            end else begin
                cap_cnt_d = cnt_eff;
            end
        end

        // The closing bank is still CAPT in bank_q, so a same-cycle reopen lands on the other bank.
        if (frame_start && ((cap_state_q == CAP_IDLE) || frame_end)) begin
            cap_state_d = CAP_ACTIVE;
            cap_cnt_d   = '0;
            cap_disc_d  = !(free0 || free1);
            cap_bank_d  = !free0;
            if (free0 || free1) begin
                bank_d[!free0] = BANK_CAPT;
            end
        end

        if (dr_state_q == DR_SEND) begin
            if (o_ready) begin
                if (dr_idx_q == last_idx) begin
                    dr_state_d        = DR_IDLE;
                    dr_idx_d          = '0;
                    bank_d[dr_bank_q] = BANK_FREE;
                end else begin
                    dr_idx_d = dr_idx_q + 1'b1;
                end
            end
        end else if ((bank_d[0] == BANK_FULL) || (bank_d[1] == BANK_FULL)) begin
            // Looking at bank_d lets a bank committing this cycle start draining without a bubble.
            dr_sel = ((bank_d[0] == BANK_FULL) && (bank_d[1] == BANK_FULL)) ? first_d
                                                                             : (bank_d[1] == BANK_FULL);
            bank_d[dr_sel] = BANK_DRAIN;
            dr_bank_d      = dr_sel;
            dr_idx_d       = '0;
            dr_state_d     = DR_SEND;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]     <= BANK_FREE;
            bank_q[1]     <= BANK_FREE;
            bank_cnt_q[0] <= '0;
            bank_cnt_q[1] <= '0;
            cap_state_q   <= CAP_IDLE;
            cap_bank_q    <= 1'b0;
            cap_disc_q    <= 1'b0;
            cap_cnt_q     <= '0;
            first_q       <= 1'b0;
            drop_q        <= '0;
            irq_q         <= 1'b0;
            dr_state_q    <= DR_IDLE;
            dr_bank_q     <= 1'b0;
            dr_idx_q      <= '0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            bank_cnt_q[0] <= bank_cnt_d[0];
            bank_cnt_q[1] <= bank_cnt_d[1];
            cap_state_q   <= cap_state_d;
            cap_bank_q    <= cap_bank_d;
            cap_disc_q    <= cap_disc_d;
            cap_cnt_q     <= cap_cnt_d;
            first_q       <= first_d;
            drop_q        <= drop_d;
            irq_q         <= irq_d;
            dr_state_q    <= dr_state_d;
            dr_bank_q     <= dr_bank_d;
            dr_idx_q      <= dr_idx_d;
        end
    end

    // Slot storage carries no reset; bank state alone decides what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tof_mem[cap_bank_q][wr_slot] <= hit_tof;
            int_mem[cap_bank_q][wr_slot] <= hit_int;
        end
    end

    assign o_valid  = (dr_state_q == DR_SEND);
    assign o_data   = o_valid ? tof_mem[dr_bank_q][dr_idx_q] : '0;
    assign o_int    = o_valid ? int_mem[dr_bank_q][dr_idx_q] : '0;
    assign o_num    = o_valid ? bank_cnt_q[dr_bank_q] : '0;
    assign o_last   = o_valid && (dr_idx_q == last_idx);
    assign o_irq    = irq_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_tdc_hit_buffer.sv
// Bench for tdc_hit_buffer: directed scenarios plus random traffic against a frame-queue model.
module tb_tdc_hit_buffer;

    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0, frame_end = 1'b0, hit_valid = 1'b0, o_ready = 1'b0;
    logic [9:0] hit_tof = '0;
    logic [4:0] hit_int = '0;
    logic [9:0] o_data;
    logic [4:0] o_int;
    logic [1:0] o_num;
    logic       o_valid, o_last, o_irq;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tdc_hit_buffer #(
        .TOF_W (10),
        .INT_W (5),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .hit_valid   (hit_valid),
        .hit_tof     (hit_tof),
        .hit_int     (hit_int),
        .o_data      (o_data),
        .o_int       (o_int),
        .o_num       (o_num),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_last      (o_last),
        .o_irq       (o_irq),
        .drop_cnt    (drop_cnt)
    );

    // Model: frames awaiting or in drain, plus the frame being captured.
    int          pend_n[$];
    logic [44:0] pend_h[$];
    logic [14:0] cur_h [DEPTH];
    int          m_cur_n, m_cnt, m_beat, m_drop;
    bit          m_active, m_has_bank, m_gap, m_irq;
    logic [14:0] log_q[$];
    bit          obs_valid;
    logic [14:0] obs_e;
    int          irq_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_n.delete();
        pend_h.delete();
        m_cur_n = 0; m_cnt = 0; m_beat = 0; m_drop = 0;
        m_active = 0; m_has_bank = 0; m_gap = 0; m_irq = 0;
    endtask

    task automatic check_outputs();
        logic [44:0] h;
        logic [14:0] e;
        bit ev;
        ev = (pend_n.size() > 0) && !m_gap;
        chk("valid", 32'(o_valid), 32'(ev));
        if (ev && o_valid) begin
            h = pend_h[0];
            e = h[m_beat*15 +: 15];
            chk("data", 32'(o_data), 32'(e[14:5]));
            chk("int", 32'(o_int), 32'(e[4:0]));
            chk("num", 32'(o_num), 32'(pend_n[0]));
            chk("last", 32'(o_last), 32'(m_beat == pend_n[0] - 1));
        end
        chk("irq", 32'(o_irq), 32'(m_irq));
        chk("drop", 32'(drop_cnt), 32'(m_drop));
        obs_valid = o_valid;
        obs_e     = {o_data, o_int};
        if (o_irq) irq_seen++;
    endtask

    task automatic model_store(input logic [9:0] tof, input logic [4:0] it);
        if (m_cur_n < DEPTH) begin
            cur_h[m_cur_n] = {tof, it};
            m_cur_n++;
        end
`ifdef TDC_MAXINT_EN
        else begin
            int mi;
            mi = 0;
            for (int k = 1; k < DEPTH; k++)
                if (cur_h[k][4:0] < cur_h[mi][4:0]) mi = k;
            if (it > cur_h[mi][4:0]) cur_h[mi] = {tof, it};
        end
`endif
    endtask

    task automatic model_step(input bit fs, input bit fe, input bit hv,
                              input logic [9:0] tof, input logic [4:0] it, input bit rdy);
        int used;
        bit avail, accept;
        logic [44:0] h;
        used   = pend_n.size() + ((m_active && m_has_bank) ? 1 : 0);
        avail  = (used < 2);
        accept = (pend_n.size() > 0) && !m_gap && rdy;
        if (obs_valid && rdy) log_q.push_back(obs_e);
        m_irq = 0;
        m_gap = 0;
        if (accept) begin
            m_beat++;
            if (m_beat == pend_n[0]) begin
                void'(pend_n.pop_front());
                void'(pend_h.pop_front());
                m_beat = 0;
                m_gap  = 1;
            end
        end
        if (m_active) begin
            if (hv && !(fs && !fe)) begin
                m_cnt++;
                if (m_has_bank) model_store(tof, it);
            end
            if (fe) begin
                if (m_has_bank && m_cur_n > 0) begin
                    h = '0;
                    for (int k = 0; k < m_cur_n; k++) h[k*15 +: 15] = cur_h[k];
                    pend_n.push_back(m_cur_n);
                    pend_h.push_back(h);
                    m_irq = 1;
                end else if (!m_has_bank && m_cnt > 0 && m_drop < 255) begin
                    m_drop++;
                end
                m_active = 0;
            end else if (fs) begin
                m_cnt = 0;
                m_cur_n = 0;
            end
        end
        if (fs && (!m_active || fe)) begin
            m_active = 1; m_has_bank = avail; m_cnt = 0; m_cur_n = 0;
        end
    endtask

    task automatic cycle(input bit fs, input bit fe, input bit hv,
                         input logic [9:0] tof, input logic [4:0] it, input bit rdy);
        check_outputs();
        frame_start = fs; frame_end = fe; hit_valid = hv;
        hit_tof = tof; hit_int = it; o_ready = rdy;
        model_step(fs, fe, hv, tof, it, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, '0, '0, rdy);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [14:0] exp);
        if (log_q.size() > idx) chk(name, 32'(log_q[idx]), 32'(exp));
        else chk(name, 32'hDEAD, 32'(exp));
    endtask

    initial begin
        bit fs, fe, hv, rdy;
        model_reset();
        irq_seen = 0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_num", 32'(o_num), 0);
        chk("rst_irq", 32'(o_irq), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b0;

        // Single frame, two hits.
        log_q.delete(); irq_seen = 0;
        cycle(1, 0, 0, '0, '0, 1);
        cycle(0, 0, 1, 10'h05A, 5'd3, 1);
        cycle(0, 0, 1, 10'h10F, 5'd7, 1);
        cycle(0, 1, 0, '0, '0, 1);
        idle(6, 1);
        chk("sc1_beats", 32'(log_q.size()), 2);
        chk_log("sc1_b0", 0, {10'h05A, 5'd3});
        chk_log("sc1_b1", 1, {10'h10F, 5'd7});
        chk("sc1_irqs", 32'(irq_seen), 1);

        // Five hits into a three-slot bank.
        log_q.delete();
        cycle(1, 0, 0, '0, '0, 1);
        cycle(0, 0, 1, 10'h101, 5'd4, 1);
        cycle(0, 0, 1, 10'h102, 5'd2, 1);
        cycle(0, 0, 1, 10'h103, 5'd6, 1);
        cycle(0, 0, 1, 10'h104, 5'd1, 1);
        cycle(0, 0, 1, 10'h105, 5'd5, 1);
        cycle(0, 1, 0, '0, '0, 1);
        idle(6, 1);
        chk("sc2_beats", 32'(log_q.size()), 3);
        chk_log("sc2_b0", 0, {10'h101, 5'd4});
`ifdef TDC_MAXINT_EN
        chk_log("sc2_b1", 1, {10'h105, 5'd5});
`else
        chk_log("sc2_b1", 1, {10'h102, 5'd2});
`endif
        chk_log("sc2_b2", 2, {10'h103, 5'd6});

        // Back-pressure on the first beat.
        log_q.delete();
        cycle(1, 0, 0, '0, '0, 0);
        cycle(0, 0, 1, 10'h0AA, 5'd9, 0);
        cycle(0, 0, 1, 10'h0BB, 5'd10, 0);
        cycle(0, 1, 0, '0, '0, 0);
        idle(4, 0);
        idle(6, 1);
        chk_log("sc3_b0", 0, {10'h0AA, 5'd9});
        chk_log("sc3_b1", 1, {10'h0BB, 5'd10});

        // Three frames with the sink stalled: third has no bank.
        log_q.delete();
        for (int f = 1; f <= 3; f++) begin
            cycle(1, 0, 0, '0, '0, 0);
            cycle(0, 0, 1, 10'(f * 17), 5'(f), 0);
            cycle(0, 1, 0, '0, '0, 0);
        end
        idle(3, 0);
        chk("sc4_drop", 32'(drop_cnt), 1);
        idle(8, 1);
        chk("sc4_beats", 32'(log_q.size()), 2);
        chk_log("sc4_f1", 0, {10'd17, 5'd1});
        chk_log("sc4_f2", 1, {10'd34, 5'd2});

        // Empty frame.
        irq_seen = 0;
        cycle(1, 0, 0, '0, '0, 1);
        cycle(0, 1, 0, '0, '0, 1);
        idle(4, 1);
        chk("sc5_irqs", 32'(irq_seen), 0);

        // Reset in the middle of a burst.
        cycle(1, 0, 0, '0, '0, 1);
        cycle(0, 0, 1, 10'h0C1, 5'd1, 1);
        cycle(0, 0, 1, 10'h0C2, 5'd2, 1);
        cycle(0, 0, 1, 10'h0C3, 5'd3, 1);
        cycle(0, 1, 0, '0, '0, 1);
        cycle(0, 0, 0, '0, '0, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_last", 32'(o_last), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        frame_start = 0; frame_end = 0; hit_valid = 0;
        model_reset();
        obs_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        log_q.delete();
        cycle(1, 0, 0, '0, '0, 1);
        cycle(0, 0, 1, 10'h0D1, 5'd4, 1);
        cycle(0, 1, 0, '0, '0, 1);
        idle(5, 1);
        chk("sc6_beats", 32'(log_q.size()), 1);
        chk_log("sc6_b0", 0, {10'h0D1, 5'd4});

        // Random traffic, alternating free-flowing and congested sink phases.
        for (int i = 0; i < 3000; i++) begin
            fs  = ($urandom_range(0, 9) == 0);
            fe  = ($urandom_range(0, 7) == 0);
            hv  = ($urandom_range(0, 2) == 0);
            rdy = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            cycle(fs, fe, hv, 10'($urandom), 5'($urandom), rdy);
        end
        idle(30, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
